uart_rx_ext: RTL and testbench

Parametrised next-generation UART receiver for the ASIC system's serial path; replaces the fixed 8-bit receiver top.
- Runtime-selectable data length (5..DATA_WIDTH bits), 1 or 2 stop bits, even/odd/no parity.
- 3-sample majority vote per bit, start-bit glitch rejection and line-break detection.
- Outputs a parallel word with a one-cycle valid pulse and per-frame error pulses.

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_rx_sampler.sv | 52 +++++
 rtl/uart_rx_ext.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding, parity constants and data-length clamp
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [3:0] MIN_DATA_BITS = 4'd5;

    function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                   input logic [3:0] max_bits);
        if (req < MIN_DATA_BITS)
            return MIN_DATA_BITS;
        else if (req > max_bits)
            return max_bits;
        else
            return req;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit oversampling counter and 3-sample majority vote
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  rx,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  bit_end
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic                  s0;
    logic                  s1;

    assign half = prescale >> 1;

    // Held at zero while the receiver is idle so a new bit period starts cleanly.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            edge_cnt <= '0;
        end else if (edge_cnt == prescale - ONE) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else if (run) begin
            if (edge_cnt == half - ONE)
                s0 <= rx;
            if (edge_cnt == half)
                s1 <= rx;
        end
    end

    // Third sample is the live line value on the vote cycle.
    assign sampled_bit  = (s0 & s1) | (s0 & rx) | (s1 & rx);
    assign sample_valid = run && (edge_cnt == half + ONE);
    assign bit_end      = run && (edge_cnt == prescale - ONE);

endmodule

// File: rtl/uart_rx_ext.sv
// rtl/uart_rx_ext.sv - configurable UART receiver with parity, framing and break detection
module uart_rx_ext
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESCALE_W  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [3:0]            data_bits,
    input  logic                  par_en,
    input  logic                  par_type,
    input  logic                  stop_bits,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  break_detect
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx;
    logic                   rx_prev;

    state_t                  state;
    logic [PRESCALE_W-1:0]   cfg_prescale;
    logic [3:0]              cfg_bits;
    logic                    cfg_par_en;
    logic                    cfg_par_type;
    logic                    cfg_stop2;
    logic [3:0]              bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    par_acc;
    logic                    par_bit;
    logic                    par_err;
    logic                    frm_err;
    logic                    stop_idx;
    logic                    first_stop;

    logic run;
    logic sampled_bit;
    logic sample_valid;
    logic bit_end;
    logic last_data;
    logic final_stop;
    logic first_stop_bit;
    logic frm_now;
    logic is_break;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '1;
            rx_prev  <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_in};
            rx_prev  <= rx;
        end
    end

    assign rx  = sync_reg[SYNC_STAGES-1];
    assign run = (state != ST_IDLE) && (state != ST_WAIT_HIGH);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .rx           (rx),
        .prescale     (cfg_prescale),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .bit_end      (bit_end)
    );

    assign last_data      = (bit_cnt == cfg_bits - 4'd1);
    assign final_stop     = !cfg_stop2 || stop_idx;
    assign first_stop_bit = stop_idx ? first_stop : sampled_bit;
    assign frm_now        = frm_err || !sampled_bit;
    assign is_break       = (shift_reg == '0) && !(cfg_par_en && par_bit) && !first_stop_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cfg_prescale  <= '0;
            cfg_bits      <= MIN_DATA_BITS;
            cfg_par_en    <= 1'b0;
            cfg_par_type  <= PAR_EVEN;
            cfg_stop2     <= 1'b0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            par_acc       <= 1'b0;
            par_bit       <= 1'b0;
            par_err       <= 1'b0;
            frm_err       <= 1'b0;
            stop_idx      <= 1'b0;
            first_stop    <= 1'b1;
            p_data        <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            break_detect  <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            break_detect  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx) begin
                        state        <= ST_START;
                        cfg_prescale <= prescale;
                        cfg_bits     <= clamp_data_bits(data_bits, 4'(DATA_WIDTH));
                        cfg_par_en   <= par_en;
                        cfg_par_type <= par_type;
                        cfg_stop2    <= stop_bits;
                        bit_cnt      <= '0;
                        shift_reg    <= '0;
                        par_acc      <= 1'b0;
                        par_bit      <= 1'b0;
                        par_err      <= 1'b0;
                        frm_err      <= 1'b0;
                        stop_idx     <= 1'b0;
                        first_stop   <= 1'b1;
                    end
                end

                ST_START: begin
                    if (sample_valid && sampled_bit)
                        state <= ST_IDLE;
                    else if (bit_end)
                        state <= ST_DATA;
                end

                ST_DATA: begin
                    if (sample_valid) begin
                        for (int i = 0; i < DATA_WIDTH; i++) begin
                            if (bit_cnt == 4'(i))
                                shift_reg[i] <= sampled_bit;
                        end
                        par_acc <= par_acc ^ sampled_bit;
                    end
                    if (bit_end) begin
                        if (last_data)
                            state <= cfg_par_en ? ST_PARITY : ST_STOP;
                        else
                            bit_cnt <= bit_cnt + 4'd1;
                    end
                end

                ST_PARITY: begin
                    if (sample_valid) begin
                        par_bit <= sampled_bit;
                        par_err <= sampled_bit != ((cfg_par_type == PAR_ODD) ? ~par_acc : par_acc);
                    end
                    if (bit_end)
                        state <= ST_STOP;
                end

                // Completes on the final stop vote, not at bit end, so back-to-back frames line up.
                ST_STOP: begin
                    if (sample_valid) begin
                        if (!final_stop) begin
                            stop_idx   <= 1'b1;
                            first_stop <= sampled_bit;
                            frm_err    <= frm_now;
                        end else begin
                            if (is_break) begin
                                break_detect <= 1'b1;
                                state        <= ST_WAIT_HIGH;
                            end else begin
                                p_data <= shift_reg;
                                state  <= ST_IDLE;
                                if (par_err || frm_now) begin
                                    parity_error  <= par_err;
                                    framing_error <= frm_now;
                                end else begin
                                    data_valid <= 1'b1;
                                end
                            end
                        end
                    end
                end

                ST_WAIT_HIGH: begin
                    if (rx)
                        state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb/tb_uart_rx_ext.sv - directed scoreboard bench for uart_rx_ext
module tb_uart_rx_ext;

    logic       TX_CLK_TB;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic [3:0] data_bits;
    logic       par_en;
    logic       par_type;
    logic       stop_bits;
    logic [7:0] p_data;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       break_detect;

    typedef struct {
        logic       valid;
        logic       perr;
        logic       ferr;
        logic       brk;
        logic [7:0] pdata;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] last_pdata = 8'h00;

    uart_rx_ext dut (
        .clk           (TX_CLK_TB),
        .rst           (rst),
        .rx_in         (rx_in),
        .prescale      (prescale),
        .data_bits     (data_bits),
        .par_en        (par_en),
        .par_type      (par_type),
        .stop_bits     (stop_bits),
        .p_data        (p_data),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .break_detect  (break_detect)
    );

    initial TX_CLK_TB = 1'b0;
    always #5 TX_CLK_TB = ~TX_CLK_TB;

    always @(posedge TX_CLK_TB) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge TX_CLK_TB) begin
        if (data_valid || parity_error || framing_error || break_detect) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {28'd0, data_valid, parity_error, framing_error, break_detect}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("data_valid", 32'(data_valid), 32'(mon_e.valid));
                chk("parity_error", 32'(parity_error), 32'(mon_e.perr));
                chk("framing_error", 32'(framing_error), 32'(mon_e.ferr));
                chk("break_detect", 32'(break_detect), 32'(mon_e.brk));
                chk("p_data", 32'(p_data), 32'(mon_e.pdata));
                chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic drive_bit(input logic v, input int p);
        @(posedge TX_CLK_TB);
        #1;
        rx_in = v;
        repeat (p - 1) @(posedge TX_CLK_TB);
    endtask

    task automatic idle(input int n);
        @(posedge TX_CLK_TB);
        #1;
        rx_in = 1'b1;
        repeat (n) @(posedge TX_CLK_TB);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && sb.size() != 0; i++)
            @(posedge TX_CLK_TB);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic pen,
                              input logic podd, input logic pflip, input logic stop1,
                              input logic stop2, input logic two_stop, input int p,
                              input logic [3:0] mid_db);
        logic [7:0] d;
        logic       pbit;
        exp_t       e;
        int         s;
        d    = data & 8'((32'd1 << nbits) - 1);
        pbit = (^d) ^ podd ^ pflip;
        prescale  = 6'(p);
        data_bits = 4'(nbits);
        par_en    = pen;
        par_type  = podd;
        stop_bits = two_stop;
        e.perr = pen & pflip;
        e.ferr = !stop1 || (two_stop && !stop2);
        e.brk  = (d == 8'h00) && !(pen && pbit) && !stop1;
        if (e.brk) begin
            e.valid = 1'b0;
            e.perr  = 1'b0;
            e.ferr  = 1'b0;
            e.pdata = last_pdata;
        end else begin
            e.valid    = !e.perr && !e.ferr;
            e.pdata    = d;
            last_pdata = d;
        end
        @(posedge TX_CLK_TB);
        #1;
        rx_in = 1'b0;
        s = cyc;
        repeat (p - 1) @(posedge TX_CLK_TB);
        // Frame result appears one cycle after the vote in the final stop bit.
        e.cyc = s + (nbits + 1 + int'(pen) + int'(two_stop)) * p + p / 2 + 5;
        sb.push_back(e);
        if (mid_db != 4'd0)
            data_bits = mid_db;
        for (int i = 0; i < nbits; i++)
            drive_bit(d[i], p);
        if (pen)
            drive_bit(pbit, p);
        drive_bit(stop1, p);
        if (two_stop)
            drive_bit(stop2, p);
        data_bits = 4'(nbits);
    endtask

    initial begin
        exp_t brk_e;
        int   s;
        rst       = 1'b1;
        rx_in     = 1'b1;
        prescale  = 6'd16;
        data_bits = 4'd8;
        par_en    = 1'b0;
        par_type  = 1'b0;
        stop_bits = 1'b0;
        repeat (4) @(posedge TX_CLK_TB);
        #1;
        rst = 1'b0;
        @(negedge TX_CLK_TB);
        chk("reset_outputs", {20'd0, p_data, data_valid, parity_error, framing_error, break_detect}, 32'd0);
        idle(10);

        send_frame(8'hBB, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32, 4'd0);
        idle(40);
        drain("drain_odd_parity");
        chk("p_data_odd_parity", 32'(p_data), 32'h0BB);

        send_frame(8'h15, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8, 4'd0);
        send_frame(8'h0A, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8, 4'd0);
        idle(40);
        drain("drain_back_to_back");
        chk("p_data_back_to_back", 32'(p_data), 32'h00A);

        send_frame(8'hBB, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16, 4'd0);
        idle(40);
        drain("drain_parity_err");
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16, 4'd0);
        idle(40);
        drain("drain_framing_err");
        chk("p_data_framing_err", 32'(p_data), 32'h0A5);

        prescale = 6'd16;
        par_en   = 1'b0;
        @(posedge TX_CLK_TB);
        #1;
        rx_in = 1'b0;
        repeat (3) @(posedge TX_CLK_TB);
        #1;
        rx_in = 1'b1;
        repeat (60) @(posedge TX_CLK_TB);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 4'd0);
        idle(40);
        drain("drain_glitch");
        chk("p_data_glitch", 32'(p_data), 32'h03C);

        prescale  = 6'd16;
        data_bits = 4'd8;
        par_en    = 1'b1;
        par_type  = 1'b0;
        stop_bits = 1'b0;
        @(posedge TX_CLK_TB);
        #1;
        rx_in = 1'b0;
        s = cyc;
        brk_e.valid = 1'b0;
        brk_e.perr  = 1'b0;
        brk_e.ferr  = 1'b0;
        brk_e.brk   = 1'b1;
        brk_e.pdata = last_pdata;
        brk_e.cyc   = s + 10 * 16 + 8 + 5;
        sb.push_back(brk_e);
        repeat (12 * 16 - 1) @(posedge TX_CLK_TB);
        idle(60);
        drain("drain_break");
        chk("p_data_after_break", 32'(p_data), 32'h03C);
        send_frame(8'h81, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 4'd0);
        idle(40);
        drain("drain_after_break");

        chk("p_data_before_reset", 32'(p_data), 32'h081);
        prescale  = 6'd32;
        data_bits = 4'd8;
        par_en    = 1'b0;
        drive_bit(1'b0, 32);
        drive_bit(1'b0, 32);
        drive_bit(1'b1, 32);
        drive_bit(1'b0, 32);
        @(posedge TX_CLK_TB);
        #1;
        rx_in = 1'b1;
        repeat (10) @(posedge TX_CLK_TB);
        #1;
        rst = 1'b1;
        @(posedge TX_CLK_TB);
        #1;
        rst = 1'b0;
        @(negedge TX_CLK_TB);
        chk("mid_frame_reset", {20'd0, p_data, data_valid, parity_error, framing_error, break_detect}, 32'd0);
        last_pdata = 8'h00;
        idle(100);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32, 4'd5);
        idle(40);
        drain("drain_after_reset");
        chk("p_data_after_reset", 32'(p_data), 32'h05A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
